sbg_et: RTL
===========

Name: sbg_et

Overview:
- Early-terminating stochastic bitstream generator: the binary-to-stochastic counterpart of the variable-precision stochastic-to-binary counter.
- Converts a W-bit unsigned value into a unipolar bitstream using a bit-reversed (van der Corput) counter comparator, so every power-of-two prefix is a correct lower-precision encoding.
- Emits the same rshift precision-boundary strobe the counter consumes, plus valid/ready flow control and a last marker, so a stream can be cut at any 2^k length.

Parameters:
- W, 6, value width; maximum stream length is 2^W.
- LW, $clog2(W+1), width of the requested length-exponent input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new stream; sampled only in IDLE.
- x  in  W  unsigned value to encode; captured on accepted start.
- len  in  LW  requested length exponent k; stream length 2^k; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- z_valid  out  1  z, rshift and z_last are valid.
- z_ready  in  1  downstream accepts the current bit.
- z  out  1  stream bit.
- rshift  out  1  current bit index is a power of two greater than 0.
- z_last  out  1  current bit is the final bit of the stream.
- done  out  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (async, active-high): state IDLE; cnt=0; x_q=0; len_q=0; all outputs 0. Reset mid-stream aborts the stream; no done pulse.
- States:
  - IDLE -> RUN on start (same edge captures x_q=x and len_q=min(len,W)).
  - RUN -> DONE on handshake (z_valid && z_ready) with z_last=1.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- start is ignored outside IDLE. start is not accepted in the DONE cycle, so back-to-back streams have a gap of one cycle.
- RUN outputs, combinational from registers:
  - z_valid=1.
  - z = (x_q > bitrev_W(cnt)), with cnt W bits wide.
  - rshift = (cnt != 0) && ((cnt & (cnt-1)) == 0).
  - z_last = (cnt == 2^len_q - 1).
- cnt increments only on handshake. With z_ready=0, all outputs hold stable.
- In IDLE and DONE: z_valid=0; z, rshift and z_last are 0.
- Latency: first bit is valid on the cycle after start is accepted. Stream length is exactly 2^len_q accepted bits.
- Precision property: the ones count in the first 2^k bits equals ceil(x_q / 2^(W-k)). At k=W the count equals x_q exactly.
- Edge cases:
  - len_q=0 gives one bit, z = (x_q != 0), rshift=0, z_last=1.
  - len > W is clamped to W.
  - cnt never wraps, because the last index is at most 2^W-1.

Optional Feature:
- Macro SBG_ET_AUTO_EN.
- Defined: at start, compute tz = trailing zeros of x (tz=W when x=0). Then len_q = min(len, W, W-tz), where W-tz is the shortest length that encodes x exactly; the stream terminates early once exact.
- Undefined: len_q = min(len, W); no trailing-zero logic is synthesised.

Test Plan:
- W=6, x=6'b100000, len=4, z_ready=1: 16 bits z=1,0,1,0,...; 8 ones; rshift at indices 1,2,4,8; z_last at index 15; done pulses on the next cycle, then busy=0.
- x=40, len=6, z_ready toggling every other cycle: exactly 64 accepted bits with 40 ones; outputs stable while z_ready=0; the 8-bit prefix holds 5 ones.
- start=1 with len=2 at cycle 3 of a len=4 run: ignored, run completes at 16 bits; start on the first IDLE cycle is accepted.
- len=7 (exceeds W): 64-bit stream; len=0, x=0: single bit z=0, z_last=1; len=0, x=1: z=1.
- Assert rst at index 5 of a run: all outputs 0 immediately, no done; a new start after release yields a clean stream from index 0.
- With SBG_ET_AUTO_EN, x=40, len=6: stream length 8, 5 ones, z_last at index 7. x=0: length 1, z=0. Without the macro: length 64.

Source files
------------

// File: rtl/sbg_et.sv
// sbg_et: early-terminating stochastic bitstream generator.
// Encodes an unsigned W-bit value as a unipolar bitstream by comparing it
// against a bit-reversed (van der Corput) counter, so that every 2^k prefix
// of the stream is itself a valid lower-precision encoding of the value.
// The stream is emitted under valid/ready flow control with a last marker
// and a precision-boundary strobe (rshift) at every power-of-two index.
//
// Optional build macro: SBG_ET_AUTO_EN
//   When defined, the captured length is also limited to the shortest
//   length that encodes x exactly (W minus the trailing zeros of x), so
//   the stream terminates as soon as it is exact.

module sbg_et #(
  parameter int W  = 6,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          z_valid,
  input  logic          z_ready,
  output logic          z,
  output logic          rshift,
  output logic          z_last,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [W-1:0]  CNT_ONE  = 1;
  localparam logic [W:0]    WIDE_ONE = 1;
  localparam logic [LW-1:0] LEN_MAX  = LW'(W);

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_rev;
  logic [W-1:0]  x_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_cap;
  logic [W:0]    last_idx;
  logic          is_last;

`ifdef SBG_ET_AUTO_EN
  logic [LW-1:0] tz;
  logic [LW-1:0] exact_len;
`endif

  // Length exponent to capture on start: clamped to W, and with the
  // auto feature also to the shortest exact length of x.
  always_comb begin
    len_cap = (len > LEN_MAX) ? LEN_MAX : len;
`ifdef SBG_ET_AUTO_EN
    tz = LEN_MAX;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) tz = LW'(i);
    end
    exact_len = LEN_MAX - tz;
    if (exact_len < len_cap) len_cap = exact_len;
`endif
  end

  // Bit-reversed counter and final-index detection for the comparator.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      cnt_rev[i] = cnt[W-1-i];
    end
    last_idx = (WIDE_ONE << len_q) - WIDE_ONE;
    is_last  = ({1'b0, cnt} == last_idx);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and all outputs, decoded from the registered state.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    z_valid  = 1'b0;
    z        = 1'b0;
    rshift   = 1'b0;
    z_last   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        z_valid = 1'b1;
        z       = (x_q > cnt_rev);
        rshift  = (cnt != '0) && ((cnt & (cnt - CNT_ONE)) == '0);
        z_last  = is_last;
        if (z_ready && is_last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture on accepted start; counter advances on each accepted
  // bit except the last, so it never wraps past the final index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      x_q   <= '0;
      len_q <= '0;
    end else if (state == IDLE && start) begin
      cnt   <= '0;
      x_q   <= x;
      len_q <= len_cap;
    end else if (state == RUN && z_ready && !is_last) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule
